// File: rtl/stopwatch_pkg.sv
// Shared state encoding and timebase helpers for the stopwatch control stage.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SPLIT = 2'd3
    } sw_state_e;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int calc_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button 2-FF synchronizer, stable-level debouncer and rising-edge press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = stopwatch_pkg::calc_width(DEB_CYCLES);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = level_q & ~prev_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, start/pause/split/clear FSM and tick prescaler.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 10,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_split,
    output logic       tick,
    output logic       clear,
    output logic       running,
    output logic       freeze,
    output logic [1:0] state
);
    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = calc_width(DIV);

    if (DIV < 2) begin : g_div_check
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end

    logic [2:0] btn_raw, btn_press, lvl_unused;
    logic       start_p, clear_p, split_p;

    assign btn_raw = {btn_split, btn_clear, btn_start};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[i]),
            .level (lvl_unused[i]),
            .press (btn_press[i])
        );
    end

    assign {split_p, clear_p, start_p} = btn_press;

    sw_state_e     state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d, clear_q, clear_d;
    logic          running_q, running_d, freeze_q, freeze_d;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;

        // Wrap is judged on the current state, so a pause in the wrap cycle still ticks.
        case (state_q)
            ST_RUN, ST_SPLIT: begin
                if (pre_q == PW'(DIV - 1)) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            ST_PAUSE: pre_d = pre_q;
            default:  pre_d = '0;
        endcase

        if (start_p) begin
            state_d = (state_q == ST_RUN || state_q == ST_SPLIT) ? ST_PAUSE : ST_RUN;
        end else if (clear_p) begin
            if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                state_d = ST_IDLE;
                clear_d = 1'b1;
            end
        end else if (split_p) begin
            if (state_q == ST_RUN)        state_d = ST_SPLIT;
            else if (state_q == ST_SPLIT) state_d = ST_RUN;
        end

        running_d = (state_d == ST_RUN) || (state_d == ST_SPLIT);
        freeze_d  = (state_d == ST_SPLIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
            freeze_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            clear_q   <= clear_d;
            running_q <= running_d;
            freeze_q  <= freeze_d;
        end
    end

    assign tick    = tick_q;
    assign clear   = clear_q;
    assign running = running_q;
    assign freeze  = freeze_q;
    assign state   = state_q;

endmodule
